// File: rtl/uart_pkg.sv
// uart_pkg: baud select encodings and divisor/phase-width helpers for the UART baud generator
package uart_pkg;
  typedef enum logic [1:0] {
    BAUD_SEL_1200 = 2'd0,
    BAUD_SEL_2400 = 2'd1,
    BAUD_SEL_4800 = 2'd2,
    BAUD_SEL_9600 = 2'd3
  } baud_sel_e;
  // Divisor rounded to nearest: (clk + baud*os/2) / (baud*os)
  function automatic int calc_div(longint clk_freq, longint baud, longint os);
    return int'((clk_freq + baud * os / 2) / (baud * os));
  endfunction
  function automatic int calc_ph_w(int os);
    return os <= 1 ? 1 : $clog2(os);
  endfunction
endpackage

// File: rtl/uart_tick_div.sv
// uart_tick_div: clearable, enableable divider counter emitting a pulse on its terminal value
//   clk, rst    : clock, synchronous active-high reset
//   clr         : restart the count at 0 (suppresses the terminal pulse)
//   en          : advance the count
//   term_val    : terminal count value (DIV-1)
//   term        : high on an enabled, uncleared cycle whose count equals term_val
module uart_tick_div #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term_val,
  output logic             term
);
  logic [CNT_W-1:0] cnt;
  assign term = en && !clr && cnt == term_val;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt == term_val ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample and bit clock-enable generator with four selectable baud rates
//   clk, rst    : clock, synchronous active-high reset
//   en          : count enable; low freezes counters
//   baud_sel    : requested rate, applied (with restart) whenever it differs from rate_active
//   rx_align    : pulse that restarts the bit phase on a detected start bit
//   os_tick     : 1-cycle pulse every DIV clocks
//   bit_tick    : 1-cycle pulse every DIV*OVERSAMPLE clocks, coincident with os_tick
//   os_phase    : oversample index within the current bit
//   rate_active : rate currently applied
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int BAUD0      = 1200,
  parameter int BAUD1      = 2400,
  parameter int BAUD2      = 4800,
  parameter int BAUD3      = 9600,
  parameter int CNT_W      = 16,
  localparam int PH_W      = calc_ph_w(OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      baud_sel,
  input  logic            rx_align,
  output logic            os_tick,
  output logic            bit_tick,
  output logic [PH_W-1:0] os_phase,
  output logic [1:0]      rate_active
);
  localparam int DIV0 = calc_div(CLK_FREQ, BAUD0, OVERSAMPLE);
  localparam int DIV1 = calc_div(CLK_FREQ, BAUD1, OVERSAMPLE);
  localparam int DIV2 = calc_div(CLK_FREQ, BAUD2, OVERSAMPLE);
  localparam int DIV3 = calc_div(CLK_FREQ, BAUD3, OVERSAMPLE);
  localparam int DMAX = 2 ** CNT_W - 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  if (DIV0 < 2 || DIV0 > DMAX || DIV1 < 2 || DIV1 > DMAX ||
      DIV2 < 2 || DIV2 > DMAX || DIV3 < 2 || DIV3 > DMAX) begin : g_bad_div
    $error("uart_baud_gen: a derived divisor is outside 2..2**CNT_W-1");
  end
  logic             chg, clr, term;
  logic [CNT_W-1:0] term_val;
  assign chg = baud_sel != rate_active;
  assign clr = chg || rx_align;
  assign term_val = rate_active == BAUD_SEL_1200 ? CNT_W'(DIV0 - 1) :
                    rate_active == BAUD_SEL_2400 ? CNT_W'(DIV1 - 1) :
                    rate_active == BAUD_SEL_4800 ? CNT_W'(DIV2 - 1) : CNT_W'(DIV3 - 1);
  uart_tick_div #(.CNT_W(CNT_W)) u_div (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .term_val(term_val), .term(term)
  );
  always_ff @(posedge clk)
    if (rst) begin
      os_tick     <= 1'b0;
      bit_tick    <= 1'b0;
      os_phase    <= '0;
      rate_active <= 2'd0;
    end else begin
      os_tick  <= term;
      bit_tick <= term && os_phase == PH_LAST;
      if (chg) rate_active <= baud_sel;
      if (clr) os_phase <= '0;
      else if (term) os_phase <= os_phase == PH_LAST ? '0 : os_phase + PH_W'(1);
    end
endmodule
